// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised event/timer counter: direction and
// mode encodings plus the next-count rule used by the counter datapath.
package counter_pkg;

    // Direction encoding on up_down
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bound behaviour encoding on saturate
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter the helper functions handle; narrower counters are
    // zero-extended into this word and truncated back by the caller.
    localparam int CNT_MAX_W = 32;

    typedef logic [CNT_MAX_W-1:0] cnt_word_t;

    // True when a step taken from 'count' in direction 'dir' hits the bound.
    // Counting up, anything at or above modulo is at the bound, so a value
    // loaded above modulo wraps/saturates on its first up step.
    function automatic logic bound_hit(
        input cnt_word_t count,
        input cnt_word_t modulo,
        input logic      dir
    );
        if (dir == DIR_UP) begin
            return (count >= modulo);
        end
        return (count == '0);
    endfunction

    // Value of the counter after one step.
    function automatic cnt_word_t next_count(
        input cnt_word_t count,
        input cnt_word_t modulo,
        input logic      dir,
        input logic      mode
    );
        if (bound_hit(count, modulo, dir)) begin
            if (mode == MODE_SAT) begin
                return count;
            end
            return (dir == DIR_UP) ? '0 : modulo;
        end
        return (dir == DIR_UP) ? count + 1 : count - 1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler for param_counter: emits a one-cycle step request every
// prescale+1 enabled cycles. Disabled cycles freeze the phase.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic               step
);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               period_done;

    // A period ends when the phase counter reaches the current prescale
    // value. A phase already above a newly lowered prescale keeps counting
    // and only matches again after wrapping through zero.
    always_comb begin
        period_done = (presc_q == prescale);
        step        = enable && !clr && period_done;
    end

    // Phase counter next state: restart on clr, advance only when enabled.
    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = period_done ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/param_counter.sv
// Parametrised up/down event counter with synchronous clear and load,
// programmable modulo bound, wrap or saturate at the bound, prescaled
// stepping, a registered terminal-count pulse and a sticky overflow flag.
// WIDTH must lie in 2..CNT_MAX_W.
module param_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic               up_down,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic [WIDTH-1:0]   modulo,
    input  logic               saturate,
    input  logic [PRESC_W-1:0] prescale,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               overflow
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             overflow_q;
    logic             overflow_d;

    logic             presc_clr;
    logic             step;
    logic             hit;

    // Clear and load both restart the prescale period, so the first step
    // after either always needs a full prescale+1 enabled cycles.
    assign presc_clr = clear | load;

    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (presc_clr),
        .enable   (enable),
        .prescale (prescale),
        .step     (step)
    );

    // Bound detection on the current count for the sampled direction.
    always_comb begin
        hit = bound_hit(cnt_word_t'(count_q), cnt_word_t'(modulo), up_down);
    end

    // Next state with priority clear > load > step > hold. tc defaults low
    // so it is a single-cycle pulse following each bound-hit step.
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (load) begin
            count_d = load_value;
        end else if (step) begin
            count_d = WIDTH'(next_count(cnt_word_t'(count_q),
                                        cnt_word_t'(modulo),
                                        up_down, saturate));
            if (hit) begin
                tc_d       = 1'b1;
                overflow_d = 1'b1;
            end
        end
    end

    // Output state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign overflow = overflow_q;

endmodule
